// File: rtl/nios2_mult_arbiter.sv
// Round-robin scheduler sharing one 32x32 low-product multiplier cell among NUM_REQ requesters.
// Operands are registered onto the cell; a tag pipe routes each product back to its owner.
module nios2_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_src1,
    input  logic [32*NUM_REQ-1:0]   req_src2,
    output logic [31:0]             mul_src1,
    output logic [31:0]             mul_src2,
    input  logic [31:0]             mul_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    busy
);

    // Returns {found, index}: first requester at or after last+1, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (vld[idx]) r = {1'b1, ID_W'(idx)};
        end
        return r;
    endfunction

    logic [ID_W-1:0]        last_grant_q;
    logic [ID_W:0]          pick;
    logic                   grant_vld;
    logic [ID_W-1:0]        grant_id;

    logic [31:0]            mul_src1_q, mul_src2_q;
    logic [MUL_LATENCY:0]   tag_vld_q;
    logic [ID_W-1:0]        tag_id_q [0:MUL_LATENCY];

    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_q;
    logic [31:0]            rsp_data_q;

    // Arbitration
    always_comb begin
        pick      = rr_pick(req_valid, last_grant_q);
        grant_vld = pick[ID_W] & ~reset;
        grant_id  = pick[ID_W-1:0];
        req_ready = '0;
        if (grant_vld) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_valid_d[tag_id_q[MUL_LATENCY]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            mul_src1_q   <= '0;
            mul_src2_q   <= '0;
            tag_vld_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            // Issue stage: operands hold when idle to avoid toggling the cell
            if (grant_vld) begin
                last_grant_q <= grant_id;
                mul_src1_q   <= req_src1[32*int'(grant_id) +: 32];
                mul_src2_q   <= req_src2[32*int'(grant_id) +: 32];
            end
            tag_vld_q <= {tag_vld_q[MUL_LATENCY-1:0], grant_vld};

            // Response stage: tag at MUL_LATENCY lines up with mul_result
            if (tag_vld_q[MUL_LATENCY]) begin
                rsp_valid_q <= rsp_valid_d;
                rsp_id_q    <= tag_id_q[MUL_LATENCY];
                rsp_data_q  <= mul_result;
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    // Tag ids carry no state of their own; only the vld bits need reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_id;
        for (int i = 1; i <= MUL_LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    end

    assign mul_src1  = mul_src1_q;
    assign mul_src2  = mul_src2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    // Includes the response register so busy stays high through the rsp_valid cycle.
    assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_nios2_mult_arbiter.sv
// Directed bench: DUT A at MUL_LATENCY=1 and DUT B at MUL_LATENCY=3 share stimulus,
// each with a behavioural pipelined multiplier cell.
module tb_nios2_mult_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_src1, req_src2;

    logic [3:0]   req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
    logic [31:0]  mul_src1_a, mul_src2_a, mul_result_a, rsp_data_a;
    logic [31:0]  mul_src1_b, mul_src2_b, mul_result_b, rsp_data_b;
    logic [1:0]   rsp_id_a, rsp_id_b;
    logic         busy_a, busy_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios2_mult_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_src1(req_src1), .req_src2(req_src2), .mul_src1(mul_src1_a), .mul_src2(mul_src2_a),
        .mul_result(mul_result_a), .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a),
        .rsp_data(rsp_data_a), .busy(busy_a));

    nios2_mult_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_src1(req_src1), .req_src2(req_src2), .mul_src1(mul_src1_b), .mul_src2(mul_src2_b),
        .mul_result(mul_result_b), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b),
        .rsp_data(rsp_data_b), .busy(busy_b));

    logic [31:0] cell_b_q [0:2];
    always_ff @(posedge clk) begin
        mul_result_a <= 32'(mul_src1_a * mul_src2_a);
        cell_b_q[0]  <= 32'(mul_src1_b * mul_src2_b);
        cell_b_q[1]  <= cell_b_q[0];
        cell_b_q[2]  <= cell_b_q[1];
    end
    assign mul_result_b = cell_b_q[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*i +: 32] = a;
        req_src2[32*i +: 32] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        #1;
        vectors++;
        if (req_ready_a !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready_a);
        end
        step();
        step();
        vectors++;
        if ({rsp_valid_a, rsp_id_a, busy_a, mul_src1_a, mul_src2_a, rsp_data_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rsp_valid=%b id=%0d busy=%b src1=%h src2=%h data=%h expected all 0",
                     rsp_valid_a, rsp_id_a, busy_a, mul_src1_a, mul_src2_a, rsp_data_a);
        end
        req_valid = 4'h0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_op(1, 32'h0001_0003, 32'h0000_0005);
        req_valid = 4'b0010;
        #1;
        vectors++;
        if (req_ready_a !== 4'b0010) begin
            miscompares++; $display("FAIL single_ready: got %b expected 0010", req_ready_a);
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (mul_src1_a !== 32'h0001_0003 || mul_src2_a !== 32'h5) begin
            miscompares++; $display("FAIL single_issue: got %h,%h expected 00010003,00000005", mul_src1_a, mul_src2_a);
        end
        for (int t = 1; t <= 3; t++) begin
            vectors++;
            if (busy_a !== 1'b1) begin
                miscompares++; $display("FAIL single_busy T+%0d: got %b expected 1", t, busy_a);
            end
            if (t < 3) begin
                vectors++;
                if (rsp_valid_a !== 4'b0000) begin
                    miscompares++; $display("FAIL single_early T+%0d: got %b expected 0000", t, rsp_valid_a);
                end
                step();
            end
        end
        vectors++;
        if (rsp_valid_a !== 4'b0010 || rsp_id_a !== 2'd1 || rsp_data_a !== 32'h0005_000F) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b id=%0d data=%h expected v=0010 id=1 data=0005000f",
                     rsp_valid_a, rsp_id_a, rsp_data_a);
        end
        step();
        vectors++;
        if (rsp_valid_a !== 4'b0000 || busy_a !== 1'b0) begin
            miscompares++; $display("FAIL single_done: got v=%b busy=%b expected 0000,0", rsp_valid_a, busy_a);
        end
        step();
        step();
    endtask

    task automatic test_latency();
        set_op(1, 32'h0001_0003, 32'h0000_0005);
        req_valid = 4'b0010;
        #1;
        vectors++;
        if (req_ready_b !== 4'b0010) begin
            miscompares++; $display("FAIL lat_ready: got %b expected 0010", req_ready_b);
        end
        step();
        req_valid = 4'b0000;
        for (int t = 1; t <= 5; t++) begin
            vectors++;
            if (busy_b !== 1'b1) begin
                miscompares++; $display("FAIL lat_busy T+%0d: got %b expected 1", t, busy_b);
            end
            if (t < 5) begin
                vectors++;
                if (rsp_valid_b !== 4'b0000) begin
                    miscompares++; $display("FAIL lat_early T+%0d: got %b expected 0000", t, rsp_valid_b);
                end
                step();
            end
        end
        vectors++;
        if (rsp_valid_b !== 4'b0010 || rsp_id_b !== 2'd1 || rsp_data_b !== 32'h0005_000F) begin
            miscompares++;
            $display("FAIL lat_rsp: got v=%b id=%0d data=%h expected v=0010 id=1 data=0005000f",
                     rsp_valid_b, rsp_id_b, rsp_data_b);
        end
        step();
        vectors++;
        if (busy_b !== 1'b0 || rsp_valid_b !== 4'b0000) begin
            miscompares++; $display("FAIL lat_done: got busy=%b v=%b expected 0,0000", busy_b, rsp_valid_b);
        end
    endtask

    task automatic overflow_op(input int i, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input string name);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        set_op(i, a, b);
        req_valid = oh;
        step();
        req_valid = 4'b0000;
        step();
        step();
        vectors++;
        if (rsp_valid_a !== oh || rsp_id_a !== 2'(i) || rsp_data_a !== exp) begin
            miscompares++;
            $display("FAIL %s: got v=%b id=%0d data=%h expected v=%b id=%0d data=%h",
                     name, rsp_valid_a, rsp_id_a, rsp_data_a, oh, i, exp);
        end
        step();
        step();
        step();
    endtask

    task automatic test_overflow();
        overflow_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "ovf_ones");
        overflow_op(3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, "ovf_zero");
    endtask

    task automatic test_fairness();
        logic [31:0] exp_p [0:3];
        logic [3:0]  oh;
        exp_p[0] = 32'h200; exp_p[1] = 32'h303; exp_p[2] = 32'h408; exp_p[3] = 32'h50F;
        set_op(0, 32'd2, 32'h100);
        set_op(1, 32'd3, 32'h101);
        set_op(2, 32'd4, 32'h102);
        set_op(3, 32'd5, 32'h103);
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                oh = 4'b0001 << (c % 4);
                vectors++;
                if (req_ready_a !== oh) begin
                    miscompares++; $display("FAIL fair_grant c=%0d: got %b expected %b", c, req_ready_a, oh);
                end
            end
            if (c >= 3) begin
                oh = 4'b0001 << ((c - 3) % 4);
                vectors++;
                if (rsp_valid_a !== oh || rsp_id_a !== 2'((c - 3) % 4) || rsp_data_a !== exp_p[(c-3)%4]) begin
                    miscompares++;
                    $display("FAIL fair_rsp c=%0d: got v=%b id=%0d data=%h expected v=%b id=%0d data=%h",
                             c, rsp_valid_a, rsp_id_a, rsp_data_a, oh, (c - 3) % 4, exp_p[(c-3)%4]);
                end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g [0:2];
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1010;
            #1;
            vectors++;
            if (req_ready_a !== exp_g[c]) begin
                miscompares++; $display("FAIL wrap_grant c=%0d: got %b expected %b", c, req_ready_a, exp_g[c]);
            end
            step();
        end
        req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_reset_midflight();
        set_op(2, 32'd11, 32'd13);
        set_op(3, 32'd17, 32'd19);
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready_a !== 4'b0100) begin
            miscompares++; $display("FAIL mid_grant_T: got %b expected 0100", req_ready_a);
        end
        step();
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready_a !== 4'b1000) begin
            miscompares++; $display("FAIL mid_grant_T1: got %b expected 1000", req_ready_a);
        end
        step();
        reset = 1'b1;
        set_op(2, 32'd7, 32'd9);
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready_a !== 4'b0000) begin
            miscompares++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready_a);
        end
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid_a, rsp_id_a, busy_a, mul_src1_a, mul_src2_a, rsp_data_a} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_state: rsp_valid=%b id=%0d busy=%b src1=%h src2=%h data=%h expected all 0",
                     rsp_valid_a, rsp_id_a, busy_a, mul_src1_a, mul_src2_a, rsp_data_a);
        end
        vectors++;
        if (req_ready_a !== 4'b0100) begin
            miscompares++; $display("FAIL mid_regrant: got %b expected 0100", req_ready_a);
        end
        step();
        req_valid = 4'b0000;
        for (int t = 4; t <= 5; t++) begin
            vectors++;
            if (rsp_valid_a !== 4'b0000) begin
                miscompares++; $display("FAIL mid_no_rsp T+%0d: got %b expected 0000", t, rsp_valid_a);
            end
            step();
        end
        vectors++;
        if (rsp_valid_a !== 4'b0100 || rsp_id_a !== 2'd2 || rsp_data_a !== 32'd63) begin
            miscompares++;
            $display("FAIL mid_rsp: got v=%b id=%0d data=%h expected v=0100 id=2 data=0000003f",
                     rsp_valid_a, rsp_id_a, rsp_data_a);
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'h0;
        req_src1  = '0;
        req_src2  = '0;
        test_reset();
        test_single();
        test_latency();
        test_overflow();
        test_fairness();
        test_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
